// File: rtl/sdram_pkg.sv
// Shared FSM encoding, default geometry and byte-mask helper for the SDRAM Wishbone bridge.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } sdram_state_e;

    localparam int SDRAM_RST_DELAY = 3;
    localparam int SDRAM_ADDR_W    = 22;

    // Returns {udqm, ldqm}: reads move both bytes, writes mask the unselected lanes.
    function automatic logic [1:0] dqm_for(input logic we, input logic [1:0] sel);
        if (we) begin
            return ~sel;
        end else begin
            return 2'b00;
        end
    endfunction

endpackage

// File: rtl/sdram_rst_delay.sv
// Holds the controller in reset until RST_DELAY clk_p edges after rst falls (RST_DELAY >= 1).
module sdram_rst_delay
    import sdram_pkg::*;
#(
    parameter int RST_DELAY = SDRAM_RST_DELAY
) (
    input  logic clk_p,
    input  logic rst,
    output logic ctl_rst_n
);

    localparam int CNT_W = (RST_DELAY < 2) ? 1 : $clog2(RST_DELAY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RST_DELAY - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             rst_n_r;

    // Release counter: counts edges after reset and latches the release once reached.
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            rst_n_r <= 1'b0;
        end else if (!rst_n_r) begin
            cnt_r   <= cnt_r + CNT_W'(1);
            rst_n_r <= (cnt_r == LAST_CNT);
        end else begin
            cnt_r   <= cnt_r;
            rst_n_r <= 1'b1;
        end
    end

    assign ctl_rst_n = rst_n_r;

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone (16-bit, classic) to SDRAM controller request/ack bridge.
// Optional one-word read buffer enabled by defining SDRAM_RDBUF_EN.
module sdram_wb_bridge
    import sdram_pkg::*;
#(
    parameter int RST_DELAY = SDRAM_RST_DELAY,
    parameter int ADDR_W    = SDRAM_ADDR_W
) (
    input  logic              clk_p,
    input  logic              sdram_reset,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [1:0]        wb_sel,
    input  logic [21:1]       wb_adr,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              ctl_rst_n,
    output logic              ctl_wr_req,
    output logic              ctl_rd_req,
    input  logic              ctl_wr_ack,
    input  logic              ctl_rd_ack,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [15:0]       ctl_wdata,
    input  logic [15:0]       ctl_rdata,
    output logic              ctl_udqm,
    output logic              ctl_ldqm,
    input  logic              ctl_init_done,
    output logic              sdram_ready
);

    sdram_state_e state_r;
    logic [21:1]  adr_r;
    logic [15:0]  dat_r;
    logic         we_r;
    logic         abort_r;
    logic         wr_req_r;
    logic         rd_req_r;
    logic         udqm_r;
    logic         ldqm_r;
    logic [15:0]  dat_o_r;
    logic         ready_r;
    logic         start_s;
    logic         ctl_ack_s;
    logic         buf_hit_s;
    logic [15:0]  buf_dat_s;

    sdram_rst_delay #(
        .RST_DELAY (RST_DELAY)
    ) u_rst_delay (
        .clk_p     (clk_p),
        .rst       (sdram_reset),
        .ctl_rst_n (ctl_rst_n)
    );

    assign start_s   = (state_r == ST_IDLE) && wb_stb && ready_r && !wb_ack;
    assign ctl_ack_s = we_r ? ctl_wr_ack : ctl_rd_ack;

`ifdef SDRAM_RDBUF_EN
    logic         buf_valid_r;
    logic [21:1]  buf_adr_r;
    logic [15:0]  buf_dat_r;

    assign buf_hit_s = buf_valid_r && !wb_we && (buf_adr_r == wb_adr);
    assign buf_dat_s = buf_dat_r;

    // Read buffer: refilled by every completed controller read, invalidated by writes to its word.
    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            buf_valid_r <= 1'b0;
            buf_adr_r   <= 21'h000000;
            buf_dat_r   <= 16'h0000;
        end else if ((state_r == ST_REQ) && !we_r && ctl_rd_ack) begin
            buf_valid_r <= 1'b1;
            buf_adr_r   <= adr_r;
            buf_dat_r   <= ctl_rdata;
        end else if (start_s && wb_we && (wb_adr == buf_adr_r)) begin
            buf_valid_r <= 1'b0;
            buf_adr_r   <= buf_adr_r;
            buf_dat_r   <= buf_dat_r;
        end else begin
            buf_valid_r <= buf_valid_r;
            buf_adr_r   <= buf_adr_r;
            buf_dat_r   <= buf_dat_r;
        end
    end
`else
    assign buf_hit_s = 1'b0;
    assign buf_dat_s = 16'h0000;
`endif

    // Registered copy of the controller init status.
    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= ctl_init_done;
        end
    end

    // Transaction FSM with registered controller-side outputs.
    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            state_r  <= ST_IDLE;
            adr_r    <= 21'h000000;
            dat_r    <= 16'h0000;
            we_r     <= 1'b0;
            abort_r  <= 1'b0;
            wr_req_r <= 1'b0;
            rd_req_r <= 1'b0;
            udqm_r   <= 1'b0;
            ldqm_r   <= 1'b0;
            dat_o_r  <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        adr_r              <= wb_adr;
                        dat_r              <= wb_dat_i;
                        we_r               <= wb_we;
                        abort_r            <= 1'b0;
                        {udqm_r, ldqm_r}   <= dqm_for(wb_we, wb_sel);
                        if (buf_hit_s) begin
                            dat_o_r <= buf_dat_s;
                            state_r <= ST_ACK;
                        end else begin
                            wr_req_r <= wb_we;
                            rd_req_r <= !wb_we;
                            state_r  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A dropped strobe is remembered so the finishing request skips the ack.
                    if (!wb_stb) begin
                        abort_r <= 1'b1;
                    end
                    if (ctl_ack_s) begin
                        wr_req_r <= 1'b0;
                        rd_req_r <= 1'b0;
                        if (!we_r) begin
                            dat_o_r <= ctl_rdata;
                        end
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort_r || !wb_stb) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!wb_stb) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    wr_req_r <= 1'b0;
                    rd_req_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // The ack follows the strobe so a master dropping stb never sees a stale ack.
    assign wb_ack      = (state_r == ST_ACK) && wb_stb;
    assign wb_dat_o    = dat_o_r;
    assign ctl_wr_req  = wr_req_r;
    assign ctl_rd_req  = rd_req_r;
    assign ctl_addr    = ADDR_W'(adr_r);
    assign ctl_wdata   = dat_r;
    assign ctl_udqm    = udqm_r;
    assign ctl_ldqm    = ldqm_r;
    assign sdram_ready = ready_r;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed self-checking bench for sdram_wb_bridge with hand-computed expectations.
module tb_sdram_wb_bridge;

    logic        clk_p = 1'b0;
    logic        sdram_reset;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic [21:1] wb_adr;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack;
    logic        ctl_rst_n;
    logic        ctl_wr_req;
    logic        ctl_rd_req;
    logic        ctl_wr_ack;
    logic        ctl_rd_ack;
    logic [21:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic [15:0] ctl_rdata;
    logic        ctl_udqm;
    logic        ctl_ldqm;
    logic        ctl_init_done;
    logic        sdram_ready;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_wb_bridge #(
        .RST_DELAY (3),
        .ADDR_W    (22)
    ) dut (
        .clk_p         (clk_p),
        .sdram_reset   (sdram_reset),
        .wb_stb        (wb_stb),
        .wb_we         (wb_we),
        .wb_sel        (wb_sel),
        .wb_adr        (wb_adr),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack        (wb_ack),
        .ctl_rst_n     (ctl_rst_n),
        .ctl_wr_req    (ctl_wr_req),
        .ctl_rd_req    (ctl_rd_req),
        .ctl_wr_ack    (ctl_wr_ack),
        .ctl_rd_ack    (ctl_rd_ack),
        .ctl_addr      (ctl_addr),
        .ctl_wdata     (ctl_wdata),
        .ctl_rdata     (ctl_rdata),
        .ctl_udqm      (ctl_udqm),
        .ctl_ldqm      (ctl_ldqm),
        .ctl_init_done (ctl_init_done),
        .sdram_ready   (sdram_ready)
    );

    always #5 clk_p = ~clk_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic wb_start(input logic we, input logic [20:0] adr,
                            input logic [1:0] sel, input logic [15:0] dat);
        wb_we    = we;
        wb_adr   = adr;
        wb_sel   = sel;
        wb_dat_i = dat;
        wb_stb   = 1'b1;
    endtask

    task automatic pulse_wr_ack();
        ctl_wr_ack = 1'b1;
        tick();
        ctl_wr_ack = 1'b0;
    endtask

    task automatic pulse_rd_ack(input logic [15:0] dat);
        ctl_rdata  = dat;
        ctl_rd_ack = 1'b1;
        tick();
        ctl_rd_ack = 1'b0;
        ctl_rdata  = 16'hFFFF;
    endtask

    initial begin
        sdram_reset   = 1'b1;
        wb_stb        = 1'b0;
        wb_we         = 1'b0;
        wb_sel        = 2'b00;
        wb_adr        = 21'h000000;
        wb_dat_i      = 16'h0000;
        ctl_wr_ack    = 1'b0;
        ctl_rd_ack    = 1'b0;
        ctl_rdata     = 16'h0000;
        ctl_init_done = 1'b0;
        tick();
        tick();
        check("rst_ctl_rst_n", {31'd0, ctl_rst_n}, 32'd0);
        check("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_ready", {31'd0, sdram_ready}, 32'd0);
        check("rst_dat_o", {16'd0, wb_dat_o}, 32'd0);
        check("rst_reqs", {30'd0, ctl_wr_req, ctl_rd_req}, 32'd0);
        check("rst_dqm", {30'd0, ctl_udqm, ctl_ldqm}, 32'd0);

        // Reset release: deasserted at cycle 0, ctl_rst_n rises at cycle 3.
        sdram_reset = 1'b0;
        tick();
        check("rel_cycle1", {31'd0, ctl_rst_n}, 32'd0);
        tick();
        check("rel_cycle2", {31'd0, ctl_rst_n}, 32'd0);
        tick();
        check("rel_cycle3", {31'd0, ctl_rst_n}, 32'd1);

        // Write held pending while the controller is not ready.
        wb_start(1'b1, 21'h012345, 2'b10, 16'hA55A);
        tick();
        tick();
        check("notready_wr_req", {31'd0, ctl_wr_req}, 32'd0);
        ctl_init_done = 1'b1;
        tick();
        check("ready_copy", {31'd0, sdram_ready}, 32'd1);
        check("ready_req_not_yet", {31'd0, ctl_wr_req}, 32'd0);
        tick();
        check("wr_req", {31'd0, ctl_wr_req}, 32'd1);
        check("wr_no_rd_req", {31'd0, ctl_rd_req}, 32'd0);
        check("wr_addr", {10'd0, ctl_addr}, 32'h0001_2345);
        check("wr_wdata", {16'd0, ctl_wdata}, 32'h0000_A55A);
        check("wr_dqm", {30'd0, ctl_udqm, ctl_ldqm}, 32'h1);
        pulse_rd_ack(16'hDEAD);
        check("wrong_dir_ack_req", {31'd0, ctl_wr_req}, 32'd1);
        check("wrong_dir_ack_dat", {16'd0, wb_dat_o}, 32'd0);
        pulse_wr_ack();
        check("wr_req_drop", {31'd0, ctl_wr_req}, 32'd0);
        check("wr_ack_n1", {31'd0, wb_ack}, 32'd0);
        tick();
        check("wr_ack_n2", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        #1;
        check("wr_ack_fall", {31'd0, wb_ack}, 32'd0);
        tick();

        // Read returning 0x1234.
        wb_start(1'b0, 21'h02AAAA, 2'b01, 16'h0000);
        tick();
        check("rd_req", {30'd0, ctl_wr_req, ctl_rd_req}, 32'h1);
        check("rd_dqm", {30'd0, ctl_udqm, ctl_ldqm}, 32'h0);
        check("rd_addr", {10'd0, ctl_addr}, 32'h0002_AAAA);
        pulse_rd_ack(16'h1234);
        check("rd_dat_capture", {16'd0, wb_dat_o}, 32'h0000_1234);
        check("rd_req_drop", {31'd0, ctl_rd_req}, 32'd0);
        check("rd_ack_n1", {31'd0, wb_ack}, 32'd0);
        tick();
        check("rd_ack_n2", {31'd0, wb_ack}, 32'd1);
        check("rd_dat_hold", {16'd0, wb_dat_o}, 32'h0000_1234);
        wb_stb = 1'b0;
        tick();

        // Stray ack while idle must not disturb anything.
        pulse_rd_ack(16'h5555);
        check("stray_ack_dat", {16'd0, wb_dat_o}, 32'h0000_1234);
        check("stray_ack_reqs", {30'd0, ctl_wr_req, ctl_rd_req}, 32'd0);

        // Abort: strobe drops in REQ, request completes, no ack even if stb returns in WAIT.
        wb_start(1'b0, 21'h000055, 2'b11, 16'h0000);
        tick();
        check("abort_req", {31'd0, ctl_rd_req}, 32'd1);
        wb_stb = 1'b0;
        tick();
        check("abort_hold1", {31'd0, ctl_rd_req}, 32'd1);
        tick();
        check("abort_hold2", {31'd0, ctl_rd_req}, 32'd1);
        pulse_rd_ack(16'hBEEF);
        check("abort_req_drop", {31'd0, ctl_rd_req}, 32'd0);
        check("abort_dat", {16'd0, wb_dat_o}, 32'h0000_BEEF);
        wb_start(1'b1, 21'h000077, 2'b11, 16'h0F0F);
        #1;
        check("abort_wait_ack", {31'd0, wb_ack}, 32'd0);
        tick();
        check("abort_no_ack", {31'd0, wb_ack}, 32'd0);
        tick();
        check("post_abort_wr_req", {31'd0, ctl_wr_req}, 32'd1);
        pulse_wr_ack();
        tick();
        check("post_abort_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        tick();

        // Repeated read of 0x100, then write, then read again.
        wb_start(1'b0, 21'h000100, 2'b11, 16'h0000);
        tick();
        check("buf_first_req", {31'd0, ctl_rd_req}, 32'd1);
        pulse_rd_ack(16'hCAFE);
        tick();
        check("buf_first_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        tick();
        wb_start(1'b0, 21'h000100, 2'b11, 16'h0000);
        tick();
`ifdef SDRAM_RDBUF_EN
        check("buf_hit_ack", {31'd0, wb_ack}, 32'd1);
        check("buf_hit_no_req", {31'd0, ctl_rd_req}, 32'd0);
        check("buf_hit_dat", {16'd0, wb_dat_o}, 32'h0000_CAFE);
        wb_stb = 1'b0;
        tick();
`else
        check("nobuf_req", {31'd0, ctl_rd_req}, 32'd1);
        check("nobuf_no_ack", {31'd0, wb_ack}, 32'd0);
        pulse_rd_ack(16'hCAFE);
        tick();
        check("nobuf_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        tick();
`endif
        wb_start(1'b1, 21'h000100, 2'b01, 16'h1111);
        tick();
        check("buf_wr_req", {31'd0, ctl_wr_req}, 32'd1);
        check("buf_wr_dqm", {30'd0, ctl_udqm, ctl_ldqm}, 32'h2);
        pulse_wr_ack();
        tick();
        check("buf_wr_ack", {31'd0, wb_ack}, 32'd1);
        wb_stb = 1'b0;
        tick();
        wb_start(1'b0, 21'h000100, 2'b11, 16'h0000);
        tick();
        check("after_wr_rd_req", {31'd0, ctl_rd_req}, 32'd1);
        check("after_wr_no_ack", {31'd0, wb_ack}, 32'd0);

        // Reset in the middle of the outstanding read.
        sdram_reset = 1'b1;
        #1;
        check("midrst_rd_req", {31'd0, ctl_rd_req}, 32'd0);
        check("midrst_wb_ack", {31'd0, wb_ack}, 32'd0);
        check("midrst_rst_n", {31'd0, ctl_rst_n}, 32'd0);
        check("midrst_dat_o", {16'd0, wb_dat_o}, 32'd0);
        pulse_rd_ack(16'h9999);
        tick();
        check("midrst_ack_held", {31'd0, wb_ack}, 32'd0);
        sdram_reset = 1'b0;
        tick();
        tick();
        check("midrst_after_ack", {31'd0, wb_ack}, 32'd0);
        wb_stb = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
